// File: rtl/sobel_window_gen.sv
// 3x3 window generator for sobel_core: two line buffers plus a two-column shift window.
// matrix_pixels_o element (vector v, pix p) lives at bits [(v*3+p)*PIXEL_WIDTH +: PIXEL_WIDTH].
module sobel_window_gen #(
    parameter int unsigned IMG_WIDTH   = 640,
    parameter int unsigned IMG_HEIGHT  = 480,
    parameter int unsigned PIXEL_WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [PIXEL_WIDTH-1:0]   pixel_i,
    input  logic                     valid_i,
    input  logic                     sof_i,
    output logic                     ready_o,
    output logic [9*PIXEL_WIDTH-1:0] matrix_pixels_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic                     frame_done_o
);

    localparam int unsigned CW = $clog2(IMG_WIDTH);
    localparam int unsigned RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    typedef enum logic [0:0] {StFill, StStream} state_e;

    state_e state_q, state_d;

    logic [CW-1:0]            col_q, col_eff;
    logic [RW-1:0]            row_q, row_eff;
    logic [PIXEL_WIDTH-1:0]   lb0 [IMG_WIDTH];
    logic [PIXEL_WIDTH-1:0]   lb1 [IMG_WIDTH];
    // Columns packed top (row r-2) in the LSBs, bottom (row r) in the MSBs.
    logic [3*PIXEL_WIDTH-1:0] w1_q, w2_q, new_col;
    logic [9*PIXEL_WIDTH-1:0] matrix_q, matrix_d;
    logic                     valid_q, frame_done_q;
    logic                     accept, col_last, row_last, load, frame_end;

    assign ready_o         = !valid_q || ready_i;
    assign accept          = valid_i && ready_o;
    assign col_eff         = sof_i ? '0 : col_q;
    assign row_eff         = sof_i ? '0 : row_q;
    assign col_last        = (col_eff == COL_LAST);
    assign row_last        = (row_eff == ROW_LAST);
    assign frame_end       = accept && col_last && row_last;
    assign new_col         = {pixel_i, lb1[col_eff], lb0[col_eff]};
    assign matrix_pixels_o = matrix_q;
    assign valid_o         = valid_q;
    assign frame_done_o    = frame_done_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StFill;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            if (sof_i) begin
                state_d = StFill;
            end else begin
                unique case (state_q)
                    StFill:   if (row_eff == RW'(1) && col_last) state_d = StStream;
                    StStream: if (row_last && col_last) state_d = StFill;
                    default:  state_d = StFill;
                endcase
            end
        end
    end

    always_comb begin
        load = accept && !sof_i && (state_q == StStream) && (col_eff >= CW'(2));
    end

    always_comb begin
        logic [3*PIXEL_WIDTH-1:0] cols [3];
        cols[0]  = w1_q;
        cols[1]  = w2_q;
        cols[2]  = new_col;
        matrix_d = '0;
        for (int v = 0; v < 3; v++) begin
            for (int p = 0; p < 3; p++) begin
                matrix_d[(v*3+p)*PIXEL_WIDTH +: PIXEL_WIDTH] = cols[p][v*PIXEL_WIDTH +: PIXEL_WIDTH];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            col_q        <= '0;
            row_q        <= '0;
            valid_q      <= 1'b0;
            matrix_q     <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= frame_end;
            if (accept) begin
                if (col_last) begin
                    col_q <= '0;
                    row_q <= row_last ? '0 : row_eff + RW'(1);
                end else begin
                    col_q <= col_eff + CW'(1);
                    row_q <= row_eff;
                end
            end
            if (load) begin
                valid_q  <= 1'b1;
                matrix_q <= matrix_d;
            end else if (ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end

    // Storage only; stale contents are always overwritten before they reach a window.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            lb0[col_eff] <= lb1[col_eff];
            lb1[col_eff] <= pixel_i;
            w1_q         <= w2_q;
            w2_q         <= new_col;
        end
    end

endmodule
